booth_digit_accumulator: RTL and testbench



---
 rtl/booth_digit_accumulator.sv | 100 ++++++++++
 tb/tb_booth_digit_accumulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_digit_accumulator.sv
// rtl/booth_digit_accumulator.sv - radix-4 Booth digit decoder and product accumulator
module booth_digit_accumulator #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  output logic                 busy,
  input  logic                 dig_valid,
  output logic                 dig_ready,
  input  logic [1:0]           dig_op,
  input  logic                 dig_neg,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 err
);

  localparam int NDIG = WIDTH / 2;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW   = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   idx;
  logic [PW-1:0]     acc;
  logic [WIDTH-1:0]  x_reg;
  logic              err_reg;
  logic              dig_fire;
  logic              last_dig;
  logic [PW-1:0]     m;
  logic [PW-1:0]     pp;
  logic [PW-1:0]     pp_shift;

  assign dig_fire = dig_valid && (state == ACCUM);
  assign last_dig = (idx == IDXW'(NDIG - 1));
  assign product  = acc;
  assign err      = err_reg;

  // Magnitude is built at full product width so 2X of the most negative X cannot overflow.
  always_comb begin
    m = '0;
    case (dig_op)
      2'b01:   m = {{WIDTH{x_reg[WIDTH-1]}}, x_reg};
      2'b11:   m = {{(WIDTH-1){x_reg[WIDTH-1]}}, x_reg, 1'b0};
      default: m = '0;
    endcase
    pp       = dig_neg ? (~m + PW'(1)) : m;
    pp_shift = pp << {idx, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    dig_ready = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        busy      = 1'b1;
        dig_ready = 1'b1;
        if (dig_valid && last_dig) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      acc     <= '0;
      x_reg   <= '0;
      err_reg <= 1'b0;
    end else if (state == IDLE && start) begin
      idx     <= '0;
      acc     <= '0;
      x_reg   <= x;
      err_reg <= 1'b0;
    end else if (dig_fire) begin
      idx <= idx + IDXW'(1);
      acc <= acc + pp_shift;
      if (dig_op == 2'b10) err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_booth_digit_accumulator.sv
// tb/tb_booth_digit_accumulator.sv - randomized self-checking bench against an arithmetic product model
module tb_booth_digit_accumulator;

  localparam int WIDTH = 32;
  localparam int NDIG  = WIDTH / 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  x;
  logic              busy;
  logic              dig_valid;
  logic              dig_ready;
  logic [1:0]        dig_op;
  logic              dig_neg;
  logic              res_valid;
  logic              res_ready;
  logic [2*WIDTH-1:0] product;
  logic              err;

  int tests = 0;
  int fails = 0;
  int hs_count = 0;

  logic [1:0] dop [NDIG];
  logic       dneg[NDIG];

  booth_digit_accumulator #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .busy(busy),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_op(dig_op), .dig_neg(dig_neg),
    .res_valid(res_valid), .res_ready(res_ready), .product(product), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (res_valid && res_ready) hs_count++;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_zero();
    for (int i = 0; i < NDIG; i++) begin
      dop[i]  = 2'b00;
      dneg[i] = 1'b0;
    end
  endtask

  // Standard radix-4 recoding of y: d_i = -2*y[2i+1] + y[2i] + y[2i-1]
  task automatic encode_y(logic [WIDTH-1:0] y);
    int d;
    for (int i = 0; i < NDIG; i++) begin
      d = -2 * int'(y[2*i+1]) + int'(y[2*i]) + ((i == 0) ? 0 : int'(y[2*i-1]));
      dneg[i] = (d < 0) ? 1'b1 : ((d == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      case (d)
        0:       dop[i] = 2'b00;
        1, -1:   dop[i] = 2'b01;
        default: dop[i] = 2'b11;
      endcase
    end
  endtask

  function automatic logic [63:0] model_product(logic [WIDTH-1:0] xv);
    longint ys = 0;
    longint dv;
    for (int i = 0; i < NDIG; i++) begin
      case (dop[i])
        2'b01:   dv = 1;
        2'b11:   dv = 2;
        default: dv = 0;
      endcase
      if (dneg[i]) dv = -dv;
      ys += dv * (longint'(1) << (2 * i));
    end
    return 64'(longint'($signed(xv)) * ys);
  endfunction

  function automatic logic model_err();
    logic e = 1'b0;
    for (int i = 0; i < NDIG; i++) if (dop[i] == 2'b10) e = 1'b1;
    return e;
  endfunction

  task automatic run_product(string tag, logic [WIDTH-1:0] xv, logic [63:0] exp_p, logic exp_err,
                             bit alt_gap, int hold, bit start_in_done, bit chk_lat);
    int k, i, n, hs0;
    bit fire;
    logic [63:0] p0;
    hs0 = hs_count;
    @(negedge clk);
    start = 1'b1;
    x     = xv;
    @(posedge clk);
    k = 0;
    i = 0;
    while (i < NDIG && k < 200) begin
      @(negedge clk);
      start     = 1'b0;
      x         = $urandom;
      dig_valid = alt_gap ? ((k % 2) == 0) : 1'b1;
      dig_op    = dop[i];
      dig_neg   = dneg[i];
      fire      = dig_valid && dig_ready;
      @(posedge clk);
      k++;
      if (fire) i++;
    end
    check({tag, "_digits"}, 64'(i), 64'(NDIG));
    @(negedge clk);
    dig_valid = 1'b0;
    dig_op    = 2'($urandom);
    n = 0;
    while (!res_valid && n < 50) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      n++;
    end
    check({tag, "_res_valid"}, 64'(res_valid), 64'(1));
    if (chk_lat) check({tag, "_latency"}, 64'(k + 1), 64'(NDIG + 1));
    check({tag, "_product"}, product, exp_p);
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    p0 = product;
    for (int h = 0; h < hold; h++) begin
      start     = start_in_done;
      dig_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(res_valid), 64'(1));
      check({tag, "_hold_ready"}, 64'(dig_ready), 64'(0));
      check({tag, "_hold_prod"}, product, p0);
    end
    dig_valid = 1'b0;
    res_ready = 1'b1;
    start     = start_in_done;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    check({tag, "_drop_valid"}, 64'(res_valid), 64'(0));
    check({tag, "_idle_busy"}, 64'(busy), 64'(0));
    check({tag, "_handshakes"}, 64'(hs_count - hs0), 64'(1));
  endtask

  initial begin
    logic [WIDTH-1:0] xv, yv;
    rst = 1'b1; start = 1'b0; x = '0; dig_valid = 1'b0; dig_op = 2'b00; dig_neg = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_dig_ready", 64'(dig_ready), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_product", product, 64'(0));
    check("rst_err", 64'(err), 64'(0));
    rst = 1'b0;

    set_zero(); dop[0] = 2'b01; dop[1] = 2'b01;
    run_product("x3y5", 32'd3, 64'd15, 1'b0, 0, 0, 0, 1);

    set_zero(); dop[0] = 2'b01; dneg[0] = 1'b1;
    run_product("xm7ym1", 32'hFFFF_FFF9, 64'h0000_0000_0000_0007, 1'b0, 0, 1, 0, 1);

    set_zero(); dop[15] = 2'b11; dneg[15] = 1'b1;
    run_product("minmin", 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 0, 0, 0, 1);

    set_zero(); dop[0] = 2'b01; dop[1] = 2'b01;
    run_product("bp", 32'd3, 64'd15, 1'b0, 1, 5, 1, 0);

    set_zero(); dop[0] = 2'b10;
    run_product("illegal", 32'd1, 64'd0, 1'b1, 0, 0, 0, 1);
    set_zero(); dop[0] = 2'b01; dop[1] = 2'b01;
    run_product("after_illegal", 32'd3, 64'd15, 1'b0, 0, 0, 0, 1);

    // Abort after 7 accepted digits
    begin
      int hs0;
      hs0 = hs_count;
      @(negedge clk);
      start = 1'b1; x = 32'd12345;
      @(posedge clk);
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        start = 1'b0; dig_valid = 1'b1; dig_op = 2'b11; dig_neg = 1'b0;
        @(posedge clk);
      end
      @(negedge clk);
      dig_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_res_valid", 64'(res_valid), 64'(0));
      check("midrst_product", product, 64'(0));
      check("midrst_no_result", 64'(hs_count - hs0), 64'(0));
    end
    set_zero(); dop[0] = 2'b01; dop[1] = 2'b01;
    run_product("after_rst", 32'd3, 64'd15, 1'b0, 0, 0, 0, 1);

    encode_y(32'h8000_0000);
    run_product("enc_minmin", 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 0, 0, 0, 1);

    for (int t = 0; t < 20; t++) begin
      xv = $urandom;
      yv = $urandom;
      encode_y(yv);
      run_product("rand_y", xv, 64'(longint'($signed(xv)) * longint'($signed(yv))), 1'b0,
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 0);
    end

    for (int t = 0; t < 10; t++) begin
      xv = $urandom;
      for (int i = 0; i < NDIG; i++) begin
        dop[i]  = 2'($urandom);
        dneg[i] = 1'($urandom);
      end
      run_product("rand_dig", xv, model_product(xv), model_err(),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
